// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the IF/DM memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } gnt_e;

  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles in which a pending fetch was denied.
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             incr,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  assign at_max = (cnt == CNT_W'(STARVE_MAX));

  // Clear wins over increment; the count holds once it reaches the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (incr && !at_max) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (IF) and data (DM) requesters,
// DM-priority with starvation escape, registered one-cycle responses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  gnt_e             gnt;
  logic             at_max;
  logic [CNT_W-1:0] starve_cnt;

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .clr    (!if_req || if_gnt),
    .incr   (if_req && !if_gnt),
    .cnt    (starve_cnt),
    .at_max (at_max)
  );

  // Grant is gated by reset so nothing reaches the memory while rst is low.
  always_comb begin
    gnt = GNT_NONE;
    if (rst) begin
      if (dm_req && !(if_req && at_max)) gnt = GNT_DM;
      else if (if_req)                   gnt = GNT_IF;
    end
  end

  assign if_gnt = (gnt == GNT_IF);
  assign dm_gnt = (gnt == GNT_DM);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    unique case (gnt)
      GNT_IF: mem_addr = if_addr;
      GNT_DM: begin
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
        mem_we    = dm_we;
      end
      default: ;
    endcase
  end

  // Response stage: capture combinational read data at the end of the grant cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_rvalid <= (gnt == GNT_IF);
      dm_rvalid <= (gnt == GNT_DM);
      if (gnt == GNT_IF)            if_rdata <= mem_rdata;
      if (gnt == GNT_DM && !dm_we)  dm_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [16];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // Combinational read, synchronous write, word-indexed.
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        e_if_gnt;
    logic        e_dm_gnt;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic        e_if_rv;
    logic        e_dm_rv;
    logic [31:0] e_if_rd;
    logic [31:0] e_dm_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 | i;
    mem[2] = 32'h0050_0093;

    //         ifr  ifaddr  dmr  we   dmaddr  dmwdata       ig dg we  maddr  mwdata        irv drv ifrd           dmrd
    vecs[0] = '{1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h8, 32'h0,        1'b1, 1'b0, 32'h0050_0093, 32'h0};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 32'h4, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0050_0093, 32'h0};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0,        1'b0, 1'b1, 1'b0, 32'h4, 32'h0,        1'b0, 1'b1, 32'h0050_0093, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 32'h0050_0093, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'hC, 32'h0,        1'b0, 1'b1, 1'b0, 32'hC, 32'h0,        1'b0, 1'b1, 32'h0050_0093, 32'hA000_0003};
    vecs[5] = '{1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h4, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF,  32'hA000_0003};
    vecs[6] = '{1'b1, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0,        1'b0, 1'b1, 1'b0, 32'h8, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF,  32'h0050_0093};
    vecs[7] = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'hA000_0000, 32'h0050_0093};

    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h8;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h4; dm_wdata = 32'h1234_5678;

    // Reset state: requests present but nothing may be granted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_gnt",    {31'b0, if_gnt},    32'h0);
    chk("rst_dm_gnt",    {31'b0, dm_gnt},    32'h0);
    chk("rst_mem_we",    {31'b0, mem_we},    32'h0);
    chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'h0);
    chk("rst_dm_rvalid", {31'b0, dm_rvalid}, 32'h0);
    chk("rst_if_rdata",  if_rdata,           32'h0);
    chk("rst_dm_rdata",  dm_rdata,           32'h0);
    chk("rst_cnt",       32'(dut.starve_cnt), 32'h0);
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    rst = 1'b1;

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      if_req   = vecs[v].if_req;
      if_addr  = vecs[v].if_addr;
      dm_req   = vecs[v].dm_req;
      dm_we    = vecs[v].dm_we;
      dm_addr  = vecs[v].dm_addr;
      dm_wdata = vecs[v].dm_wdata;
      #1;
      chk($sformatf("v%0d_if_gnt", v),    {31'b0, if_gnt}, {31'b0, vecs[v].e_if_gnt});
      chk($sformatf("v%0d_dm_gnt", v),    {31'b0, dm_gnt}, {31'b0, vecs[v].e_dm_gnt});
      chk($sformatf("v%0d_mem_we", v),    {31'b0, mem_we}, {31'b0, vecs[v].e_mem_we});
      chk($sformatf("v%0d_mem_addr", v),  mem_addr,        vecs[v].e_mem_addr);
      chk($sformatf("v%0d_mem_wdata", v), mem_wdata,       vecs[v].e_mem_wdata);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_if_rvalid", v), {31'b0, if_rvalid}, {31'b0, vecs[v].e_if_rv});
      chk($sformatf("v%0d_dm_rvalid", v), {31'b0, dm_rvalid}, {31'b0, vecs[v].e_dm_rv});
      chk($sformatf("v%0d_if_rdata", v),  if_rdata,           vecs[v].e_if_rd);
      chk($sformatf("v%0d_dm_rdata", v),  dm_rdata,           vecs[v].e_dm_rd);
    end

    // Contention: DM wins four times, then IF is forced through once.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h8;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'hC;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("starve_c%0d_if_gnt", c), {31'b0, if_gnt}, (c == 4) ? 32'h1 : 32'h0);
      chk($sformatf("starve_c%0d_dm_gnt", c), {31'b0, dm_gnt}, (c == 4) ? 32'h0 : 32'h1);
      @(posedge clk);
      #1;
      chk($sformatf("starve_c%0d_cnt", c), 32'(dut.starve_cnt),
          (c < 4) ? 32'(c + 1) : (c == 4) ? 32'h0 : 32'h1);
      if (c == 4) begin
        chk("starve_if_rvalid", {31'b0, if_rvalid}, 32'h1);
        chk("starve_if_rdata",  if_rdata,           32'h0050_0093);
      end
      @(negedge clk);
    end

    // IF withdraws while being denied: count clears.
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    if_req = 1'b1; dm_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("drop_cnt_before", 32'(dut.starve_cnt), 32'h2);
    @(negedge clk);
    if_req = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_cnt_after", 32'(dut.starve_cnt), 32'h0);
    @(negedge clk);
    dm_req = 1'b0;

    // Reset asserted during a granted DM read.
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4;
    #1;
    chk("mid_rst_gnt_before", {31'b0, dm_gnt}, 32'h1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_gnt_during", {31'b0, dm_gnt}, 32'h0);
    chk("mid_rst_mem_we",     {31'b0, mem_we}, 32'h0);
    @(posedge clk);
    #1;
    chk("mid_rst_dm_rvalid", {31'b0, dm_rvalid}, 32'h0);
    chk("mid_rst_if_rvalid", {31'b0, if_rvalid}, 32'h0);
    chk("mid_rst_dm_rdata",  dm_rdata,           32'h0);
    chk("mid_rst_if_rdata",  if_rdata,           32'h0);
    chk("mid_rst_cnt",       32'(dut.starve_cnt), 32'h0);
    dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Earlier write survives reset.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h4;
    #1;
    chk("post_rst_if_gnt", {31'b0, if_gnt}, 32'h1);
    @(posedge clk);
    #1;
    chk("post_rst_if_rdata", if_rdata, 32'hDEADBEEF);
    @(negedge clk);
    if_req = 1'b0;

    // Idle stretch.
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_gnt", k),
          {30'b0, if_gnt, dm_gnt}, 32'h0);
      chk($sformatf("idle%0d_mem_we", k), {31'b0, mem_we}, 32'h0);
      chk($sformatf("idle%0d_rvalid", k), {30'b0, if_rvalid, dm_rvalid}, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported 32-bit memory between the pipeline's fetch stage (IF) and memory stage (DM). The arbiter sits between the two requesters and the memory, which has combinational read and synchronous write. Each cycle it grants at most one request. DM has priority, bounded by a starvation counter that guarantees IF forward progress. Read data and acknowledges return through registered response ports one cycle after the grant.

## Interface
- `DATA_W`, 32, data width of all data buses
- `ADDR_W`, 32, byte address width
- `STARVE_MAX`, 4, number of consecutive denied IF cycles before IF is forced to win
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset; one clock, asynchronous assert, active-low (0 = reset)
- `if_req`  in  1  fetch request (read only)
- `if_addr`  in  ADDR_W  fetch byte address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  one-cycle pulse, `if_rdata` valid
- `if_rdata`  out  DATA_W  registered fetch data
- `dm_req`  in  1  data request
- `dm_we`  in  1  1 = write, 0 = read
- `dm_addr`  in  ADDR_W  data byte address
- `dm_wdata`  in  DATA_W  write data
- `dm_gnt`  out  1  data request accepted this cycle
- `dm_rvalid`  out  1  one-cycle pulse; read data valid, or write acknowledge
- `dm_rdata`  out  DATA_W  registered read data
- `mem_addr`  out  ADDR_W  to memory (byte address, passed unchanged; memory indexes word `[31:2]`)
- `mem_wdata`  out  DATA_W  to memory
- `mem_we`  out  1  to memory write enable
- `mem_rdata`  in  DATA_W  combinational read data from memory

## Operation
- Grant is combinational from the current requests plus the registered starvation count.
- Grant rule:
  - Only one requester active: that requester wins.
  - Both active: DM wins unless `starve_cnt == STARVE_MAX`, in which case IF wins.
- Memory drive follows the winner:
  - IF grant: `mem_addr = if_addr`, `mem_we = 0`.
  - DM grant: `mem_addr = dm_addr`, `mem_wdata = dm_wdata`, `mem_we = dm_we`.
  - No grant: `mem_we = 0`, `mem_addr = 0`, `mem_wdata = 0`.
- Starvation counter (`STARVE_MAX+1` states, saturating):
  - Increments each cycle `if_req && !if_gnt`.
  - Clears on any `if_gnt`, and on any cycle with `!if_req`.
- Response path, on a granted cycle:
  - `mem_rdata` is captured into `if_rdata` or `dm_rdata` at the next edge, and the matching `rvalid` pulses high for exactly one cycle.
  - For a DM write, `dm_rvalid` pulses as the acknowledge and `dm_rdata` keeps its previous value.
- Requester rule: `req`, `addr`, `we` and `wdata` are held stable until `gnt` is seen. Behaviour if a requester drops `req` before its grant is defined: the request is simply lost.
- Back-to-back: a requester may re-request in the cycle after its grant. Throughput is one access per cycle total.

## Timing
- Reset values: `if_rvalid = 0`, `dm_rvalid = 0`, `if_rdata = 0`, `dm_rdata = 0`, `starve_cnt = 0`. Combinational outputs follow the idle rule while in reset (`gnt = 0`, `mem_we = 0`).
- Grant to response latency is 1 cycle: granted in cycle N, `rvalid` high in N+1.
- Write lands at the memory on the clock edge ending the grant cycle.
- Simultaneous requests with `starve_cnt < STARVE_MAX`: DM granted and the counter increments.
- Reset asserted mid-access: `rvalid` is cleared immediately and the pending response is discarded. A write already committed at a prior edge stays committed. After deassertion the first grant is evaluated with `starve_cnt = 0`.
- No grant is ever issued while `rst == 0`.

## Structure
- `mem_arb_pkg` holds:
  - `gnt_e` enum: `GNT_NONE`, `GNT_IF`, `GNT_DM`.
  - Default widths.
  - The `STARVE_MAX` default.
- One sub-module, `arb_starve_cnt`: the saturating counter with clear/increment inputs and an `at_max` output.
- The grant mux and response registers stay in the top level.

## Test plan
- IF alone: `if_req = 1`, `if_addr = 0x8`, memory word 2 = `0x00500093` -> `if_gnt = 1` same cycle; next cycle `if_rvalid = 1`, `if_rdata = 0x00500093`.
- DM write then read:
  - Write `dm_addr = 0x4`, `dm_wdata = 0xDEADBEEF` -> `mem_we = 1` for one cycle, then `dm_rvalid` pulses.
  - Read `0x4` next -> `dm_rdata = 0xDEADBEEF`.
- Contention with starvation (`STARVE_MAX = 4`): `if_req` and `dm_req` both held high for 6 cycles -> DM granted cycles 0–3, IF granted cycle 4, DM granted cycle 5; counter reads 0 after cycle 4.
- IF drops request: `if_req` deasserts while denied -> `starve_cnt` returns to 0.
- Reset mid-op: grant DM read in cycle N, assert `rst = 0` before edge N+1 -> `dm_rvalid` stays 0 and all registered outputs are 0.
- Idle: both requests low for 10 cycles -> `mem_we = 0`, no `gnt`, no `rvalid` at any point.
